// File: rtl/acumulador_pkg.sv
// Shared definitions for the acumulador_nota scoring block.
// Contents: FSM state codes (OCIOSO, MEDINDO, FIM) and a width helper
// used to size the score, total and round-count buses.
package acumulador_pkg;

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] MEDINDO = 2'd1;
  localparam logic [1:0] FIM     = 2'd2;

  // Bits needed to hold values 0..v-1; never returns 0 so a bus always exists.
  function automatic int largura_para(input int v);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_nota.sv
// Per-round score: nota = NOTA_MAX - |ideal - sensor|, saturating at 0.
// Ports: sensor/ideal (LARGURA) in; nota (WN) out; exato high when sensor == ideal.
// Purely combinational.
module calc_nota
  import acumulador_pkg::*;
#(
  parameter int LARGURA  = 4,
  parameter int NOTA_MAX = 10,
  localparam int WN = largura_para(NOTA_MAX + 1)
) (
  input  logic [LARGURA-1:0] sensor,
  input  logic [LARGURA-1:0] ideal,
  output logic [WN-1:0]      nota,
  output logic               exato
);

  logic [LARGURA-1:0] diff;

  always_comb begin
    // Subtract the smaller from the larger so the magnitude never wraps.
    if (ideal >= sensor) diff = ideal - sensor;
    else                 diff = sensor - ideal;

    if (int'(diff) >= NOTA_MAX) nota = '0;
    else                        nota = WN'(NOTA_MAX - int'(diff));

    exato = (diff == '0);
  end

endmodule

// File: rtl/acumulador_nota.sv
// Match scorer: accumulates per-round scores over RODADAS rounds.
// Ports: clock, reset (sync, active-high); iniciar/enable/sensor/ideal in;
// nota, nota_valida, total, melhor, acertos, rodada, pronto out (all registered, 1-cycle latency).
module acumulador_nota
  import acumulador_pkg::*;
#(
  parameter int LARGURA  = 4,
  parameter int NOTA_MAX = 10,
  parameter int RODADAS  = 4,
  localparam int WN = largura_para(NOTA_MAX + 1),
  localparam int WT = largura_para(RODADAS * NOTA_MAX + 1),
  localparam int WR = largura_para(RODADAS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               enable,
  input  logic [LARGURA-1:0] sensor,
  input  logic [LARGURA-1:0] ideal,
  output logic [WN-1:0]      nota,
  output logic               nota_valida,
  output logic [WT-1:0]      total,
  output logic [WN-1:0]      melhor,
  output logic [WR-1:0]      acertos,
  output logic [WR-1:0]      rodada,
  output logic               pronto
);

  logic [1:0]    state_q, state_d;
  logic [WN-1:0] nota_q, nota_d;
  logic          nota_valida_q, nota_valida_d;
  logic [WT-1:0] total_q, total_d;
  logic [WN-1:0] melhor_q, melhor_d;
  logic [WR-1:0] acertos_q, acertos_d;
  logic [WR-1:0] rodada_q, rodada_d;

  logic [WN-1:0] nota_rodada;
  logic          exato;

  calc_nota #(
    .LARGURA  (LARGURA),
    .NOTA_MAX (NOTA_MAX)
  ) u_calc_nota (
    .sensor (sensor),
    .ideal  (ideal),
    .nota   (nota_rodada),
    .exato  (exato)
  );

  always_comb begin
    state_d       = state_q;
    nota_d        = nota_q;
    nota_valida_d = 1'b0;
    total_d       = total_q;
    melhor_d      = melhor_q;
    acertos_d     = acertos_q;
    rodada_d      = rodada_q;

    // iniciar wins over enable in every state: the sample of that cycle is dropped.
    if (iniciar) begin
      state_d   = MEDINDO;
      nota_d    = '0;
      total_d   = '0;
      melhor_d  = '0;
      acertos_d = '0;
      rodada_d  = '0;
    end else begin
      case (state_q)
        MEDINDO: begin
          if (enable) begin
            nota_d        = nota_rodada;
            nota_valida_d = 1'b1;
            total_d       = total_q + WT'(nota_rodada);
            if (nota_rodada > melhor_q) melhor_d = nota_rodada;
            if (exato) acertos_d = acertos_q + WR'(1);
            rodada_d = rodada_q + WR'(1);
            // The final round closes the match on the same edge it is scored.
            if (rodada_q + WR'(1) == WR'(RODADAS)) state_d = FIM;
          end
        end
        OCIOSO, FIM: ;
        default: state_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= OCIOSO;
      nota_q        <= '0;
      nota_valida_q <= 1'b0;
      total_q       <= '0;
      melhor_q      <= '0;
      acertos_q     <= '0;
      rodada_q      <= '0;
    end else begin
      state_q       <= state_d;
      nota_q        <= nota_d;
      nota_valida_q <= nota_valida_d;
      total_q       <= total_d;
      melhor_q      <= melhor_d;
      acertos_q     <= acertos_d;
      rodada_q      <= rodada_d;
    end
  end

  assign nota        = nota_q;
  assign nota_valida = nota_valida_q;
  assign total       = total_q;
  assign melhor      = melhor_q;
  assign acertos     = acertos_q;
  assign rodada      = rodada_q;
  assign pronto      = (state_q == FIM);

endmodule

// File: tb/tb_acumulador_nota.sv
// Bench for acumulador_nota: directed match scenarios on a default instance
// checked every cycle against a behavioural model, plus a 256-round sweep instance.
module tb_acumulador_nota;

  logic       clock = 1'b0;
  logic       reset, iniciar, enable;
  logic [3:0] sensor, ideal;
  logic [3:0] nota;
  logic       nota_valida;
  logic [5:0] total;
  logic [3:0] melhor;
  logic [2:0] acertos, rodada;
  logic       pronto;

  logic       sw_ini, sw_en;
  logic [3:0] sw_sensor, sw_ideal;
  logic [3:0] sw_nota;
  logic       sw_val;
  logic [11:0] sw_total;
  logic [3:0] sw_melhor;
  logic [8:0] sw_acertos, sw_rodada;
  logic       sw_pronto;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Behavioural model of the default instance (plain integers).
  bit m_em_partida, m_fim;
  int m_nota, m_val, m_total, m_melhor, m_acertos, m_rodada;

  always #5 clock = ~clock;

  acumulador_nota dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .enable(enable),
    .sensor(sensor), .ideal(ideal), .nota(nota), .nota_valida(nota_valida),
    .total(total), .melhor(melhor), .acertos(acertos), .rodada(rodada),
    .pronto(pronto)
  );

  acumulador_nota #(.LARGURA(4), .NOTA_MAX(10), .RODADAS(256)) u_sweep (
    .clock(clock), .reset(reset), .iniciar(sw_ini), .enable(sw_en),
    .sensor(sw_sensor), .ideal(sw_ideal), .nota(sw_nota), .nota_valida(sw_val),
    .total(sw_total), .melhor(sw_melhor), .acertos(sw_acertos), .rodada(sw_rodada),
    .pronto(sw_pronto)
  );

  task automatic check(input string nome, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
  endtask

  function automatic int pontos(input int s, input int i);
    int d;
    d = (s > i) ? s - i : i - s;
    return (d >= 10) ? 0 : 10 - d;
  endfunction

  // Apply one cycle of inputs, advance the model with the same rules, return just after the edge.
  task automatic ciclo(input bit rst, input bit ini, input bit en, input int s, input int i);
    reset = rst; iniciar = ini; enable = en;
    sensor = 4'(s); ideal = 4'(i);
    @(posedge clock);
    m_val = 0;
    if (rst) begin
      m_em_partida = 0; m_fim = 0;
      m_nota = 0; m_total = 0; m_melhor = 0; m_acertos = 0; m_rodada = 0;
    end else if (ini) begin
      m_em_partida = 1; m_fim = 0;
      m_nota = 0; m_total = 0; m_melhor = 0; m_acertos = 0; m_rodada = 0;
    end else if (m_em_partida && en) begin
      m_nota = pontos(s, i);
      m_val = 1;
      m_total += m_nota;
      if (m_nota > m_melhor) m_melhor = m_nota;
      if (s == i) m_acertos++;
      m_rodada++;
      if (m_rodada == 4) begin
        m_em_partida = 0; m_fim = 1;
      end
    end
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      check("nota",        int'(nota),        m_nota);
      check("nota_valida", int'(nota_valida), m_val);
      check("total",       int'(total),       m_total);
      check("melhor",      int'(melhor),      m_melhor);
      check("acertos",     int'(acertos),     m_acertos);
      check("rodada",      int'(rodada),      m_rodada);
      check("pronto",      int'(pronto),      int'(m_fim));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int soma;
    sw_ini = 0; sw_en = 0; sw_sensor = 0; sw_ideal = 0;

    ciclo(1, 0, 0, 0, 0);
    ciclo(1, 0, 0, 0, 0);
    chk_on = 1'b1;
    check("rst_total",  int'(total),  0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_rodada", int'(rodada), 0);

    // enable while idle is ignored
    ciclo(0, 0, 1, 5, 5);
    ciclo(0, 0, 1, 5, 5);
    check("ocioso_valida", int'(nota_valida), 0);
    check("ocioso_rodada", int'(rodada), 0);

    // reference match
    ciclo(0, 1, 0, 0, 0);
    ciclo(0, 0, 1, 7, 7);   check("r1_nota", int'(nota), 10);
    ciclo(0, 0, 1, 3, 9);   check("r2_nota", int'(nota), 4);
    check("r2_pronto", int'(pronto), 0);
    ciclo(0, 0, 1, 15, 0);  check("r3_nota", int'(nota), 0);
    ciclo(0, 0, 1, 9, 12);  check("r4_nota", int'(nota), 7);
    check("m_total",   int'(total),   21);
    check("m_melhor",  int'(melhor),  10);
    check("m_acertos", int'(acertos), 1);
    check("m_pronto",  int'(pronto),  1);

    // enable while finished is ignored
    ciclo(0, 0, 1, 5, 5);
    ciclo(0, 0, 1, 5, 5);
    check("fim_valida", int'(nota_valida), 0);
    check("fim_total",  int'(total), 21);
    check("fim_nota",   int'(nota), 7);

    // restart mid-match discards the sample of that cycle
    ciclo(0, 1, 0, 0, 0);
    ciclo(0, 0, 1, 1, 3);
    ciclo(0, 0, 1, 8, 8);
    ciclo(0, 1, 1, 5, 5);
    check("restart_rodada", int'(rodada), 0);
    check("restart_total",  int'(total), 0);
    check("restart_valida", int'(nota_valida), 0);
    ciclo(0, 0, 1, 2, 2);
    check("restart_medindo", int'(total), 10);

    // reset during round 3
    ciclo(0, 0, 1, 6, 1);
    ciclo(1, 0, 1, 4, 4);
    check("rst_mid_total",   int'(total), 0);
    check("rst_mid_acertos", int'(acertos), 0);
    ciclo(0, 0, 1, 4, 4);
    check("rst_mid_ocioso", int'(rodada), 0);

    // four perfect back-to-back rounds
    ciclo(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) ciclo(0, 0, 1, k + 3, k + 3);
    check("perf_total",   int'(total), 40);
    check("perf_acertos", int'(acertos), 4);
    check("perf_pronto",  int'(pronto), 1);

    // reset wins in FIM, even with iniciar
    ciclo(1, 1, 1, 0, 0);
    check("rst_fim_pronto", int'(pronto), 0);
    check("rst_fim_total",  int'(total), 0);

    // exhaustive sweep on the 256-round instance
    sw_ini = 1;
    ciclo(0, 0, 0, 0, 0);
    sw_ini = 0;
    soma = 0;
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 16; i++) begin
        sw_en = 1; sw_sensor = 4'(s); sw_ideal = 4'(i);
        ciclo(0, 0, 0, 0, 0);
        soma += pontos(s, i);
        check($sformatf("sweep_nota_%0d_%0d", s, i), int'(sw_nota), pontos(s, i));
        if (!sw_val) check("sweep_valida", int'(sw_val), 1);
      end
    end
    sw_en = 0;
    ciclo(0, 0, 0, 0, 0);
    check("sweep_total",   int'(sw_total), soma);
    check("sweep_acertos", int'(sw_acertos), 16);
    check("sweep_pronto",  int'(sw_pronto), 1);
    check("sweep_valida_fim", int'(sw_val), 0);

    chk_on = 1'b0;
    @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
